// File: rtl/tdc_pkg.sv
// Shared TDC result types and default widths, common to the read controller
// and the result buffer.
package tdc_pkg;
    localparam int TDC_ADDR_W = 4;
    localparam int TDC_DATA_W = 28;
    localparam int TDC_DEPTH  = 16;
    localparam int TDC_CNT_W  = 8;

    typedef struct packed {
        logic [TDC_ADDR_W-1:0] addr;
        logic [TDC_DATA_W-1:0] data;
    } tdc_result_t;
endpackage

// File: rtl/tdc_result_fifo_mem.sv
// Register-array storage for the result FIFO.
// It has one synchronous write port and one combinational read port.
module tdc_result_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tdc_result_buffer.sv
// Masked first-word-fall-through FIFO for TDC results.
// A full FIFO drops new results and counts them, so it never stalls the read controller.
module tdc_result_buffer
    import tdc_pkg::*;
#(
    parameter int ADDR_W = TDC_ADDR_W,
    parameter int DATA_W = TDC_DATA_W,
    parameter int DEPTH  = TDC_DEPTH,
    parameter int CNT_W  = TDC_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [2**ADDR_W-1:0]     chan_en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             run;
    logic             push_req, pop, push_ok, drop;
    logic [ENT_W-1:0] head;

    // The first edge after reset release only arms the block.
    // It accepts no traffic, so release is effectively synchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run <= 1'b0;
        else       run <= 1'b1;
    end

    assign out_valid = (level != '0);
    assign full      = (level == (PTR_W+1)'(DEPTH));
    assign push_req  = run & in_valid & chan_en[in_addr];
    assign pop       = run & out_valid & out_ready;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    tdc_result_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_mem (
        .clk   (clk),
        .we    (push_ok & ~clear),
        .waddr (wr_ptr),
        .wdata ({in_addr, in_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Stale storage stays hidden while the FIFO is empty.
    assign out_addr = out_valid ? head[ENT_W-1:DATA_W] : '0;
    assign out_data = out_valid ? head[DATA_W-1:0]     : '0;
endmodule

// File: tb/tb_tdc_result_buffer.sv
// Randomised and directed bench for tdc_result_buffer.
// A queue-based reference model is checked against the DUT on every falling edge.
module tb_tdc_result_buffer;
    import tdc_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 0, reset = 1;
    logic        in_valid = 0, clear = 0, out_ready = 0;
    logic [3:0]  in_addr = 0;
    logic [27:0] in_data = 0;
    logic [15:0] chan_en = 16'hFFFF;
    logic        out_valid, full;
    logic [3:0]  out_addr;
    logic [27:0] out_data;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    int total = 0, bad = 0;

    tdc_result_buffer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
        .in_data(in_data), .chan_en(chan_en), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .level(level), .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of accepted results plus a drop tally.
    tdc_result_t mq[$];
    int          mdrop = 0;
    bit          mrun = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete(); mdrop = 0; mrun = 0;
        end else if (!mrun) begin
            mrun = 1;
        end else if (clear) begin
            mq.delete(); mdrop = 0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (in_valid && chan_en[in_addr]) begin
                if (mq.size() < DEPTH) mq.push_back('{addr: in_addr, data: in_data});
                else if (mdrop < 255) mdrop++;
            end
        end
    end

    always @(negedge clk) begin
        int          lvl;
        tdc_result_t h;
        lvl = mq.size();
        h   = (lvl != 0) ? mq[0] : '0;
        total++;
        if (out_valid !== (lvl != 0) || level !== 5'(lvl) || full !== (lvl == DEPTH) ||
            drop_cnt !== 8'(mdrop) || out_addr !== h.addr || out_data !== h.data) begin
            bad++;
            $display("FAIL model t=%0t: got v=%0b lvl=%0d full=%0b drop=%0d addr=%0d data=%0d want v=%0b lvl=%0d full=%0b drop=%0d addr=%0d data=%0d",
                     $time, out_valid, level, full, drop_cnt, out_addr, out_data,
                     lvl != 0, lvl, lvl == DEPTH, mdrop, h.addr, h.data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] a, input logic [27:0] d,
                       input logic r, input logic c = 1'b0);
        in_valid = v; in_addr = a; in_data = d; out_ready = r; clear = c;
        @(posedge clk); #2;
        in_valid = 0; out_ready = 0; clear = 0;
    endtask

    initial begin
        #100;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_full",  int'(full), 0);
        chk("rst_drop",  int'(drop_cnt), 0);
        #102 reset = 0;
        @(posedge clk); #2;
        cyc(0, 0, 0, 0);

        // single result
        cyc(1, 4'h3, 28'd1234, 0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_addr",  int'(out_addr), 3);
        chk("single_data",  int'(out_data), 1234);
        chk("single_level", int'(level), 1);
        cyc(0, 0, 0, 1);
        chk("single_pop_level", int'(level), 0);
        chk("single_pop_valid", int'(out_valid), 0);

        // channel mask
        chan_en = 16'h0001;
        cyc(1, 4'd5, 28'd7, 0);
        cyc(1, 4'd0, 28'd8, 0);
        chk("mask_level", int'(level), 1);
        chk("mask_drop",  int'(drop_cnt), 0);
        chk("mask_data",  int'(out_data), 8);
        cyc(0, 0, 0, 1);
        chan_en = 16'hFFFF;

        // overflow, then in-order drain
        for (int i = 1; i <= 18; i++) cyc(1, 4'(i), 28'(i), 0);
        chk("ovf_full",  int'(full), 1);
        chk("ovf_level", int'(level), 16);
        chk("ovf_drop",  int'(drop_cnt), 2);
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_drain", int'(out_data), i);
            cyc(0, 0, 0, 1);
        end
        chk("ovf_empty", int'(level), 0);

        // push and pop together while full
        for (int i = 0; i < 16; i++) cyc(1, 4'(i), 28'(100 + i), 0);
        cyc(1, 4'd9, 28'd99, 1);
        chk("fpp_level", int'(level), 16);
        chk("fpp_drop",  int'(drop_cnt), 2);
        for (int i = 1; i <= 16; i++) begin
            chk("fpp_drain", int'(out_data), (i == 16) ? 99 : 100 + i);
            cyc(0, 0, 0, 1);
        end

        // clear wins over a concurrent strobe
        for (int i = 0; i < 5; i++) cyc(1, 4'(i), 28'(200 + i), 0);
        cyc(1, 4'd2, 28'd55, 0, 1'b1);
        chk("clr_level", int'(level), 0);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_drop",  int'(drop_cnt), 0);

        // async reset between edges, with entries and drops present
        for (int i = 0; i < 18; i++) cyc(1, 4'(i), 28'(300 + i), 0);
        #1 reset = 1;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data",  int'(out_data), 0);
        chk("arst_drop",  int'(drop_cnt), 0);
        #2 reset = 0;
        @(posedge clk); #2;
        cyc(0, 0, 0, 0);

        // 10 random strobes, random consumer
        for (int i = 0; i < 10; i++)
            cyc(1, 4'($urandom_range(0, 15)), 28'($urandom_range(0, 9999)), 1'($urandom_range(0, 1)));
        repeat (12) cyc(0, 0, 0, 1'($urandom_range(0, 1)));

        // longer random traffic with random masks and occasional clear
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) chan_en = 16'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                28'($urandom_range(0, 9999)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 99) == 0));
        end
        repeat (20) cyc(0, 0, 0, 1);
        chk("final_level", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
